// File: rtl/reg_write_arbiter_pkg.sv
// ProcessorTypes: register-write request type and arbiter defaults shared across the write-back slice
package ProcessorTypes;
    localparam int reg_addr_w = 5;
    localparam int reg_data_w = 32;
    localparam int reg_write_arb_depth = 2;
    localparam int reg_write_arb_starve_limit = 8;

    typedef struct packed {
        logic [reg_addr_w-1:0] addr;
        logic [reg_data_w-1:0] value;
    } RegWriteReq;
endpackage

// File: rtl/reg_write_arbiter_buffer.sv
// reg_write_buffer: circular FIFO of pending long-latency writes with per-entry valid/killed bits and kill-by-address
module reg_write_buffer
    import ProcessorTypes::*;
#(
    parameter int DEPTH = reg_write_arb_depth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  RegWriteReq            i_push_req,
    input  logic                  i_pop,
    input  logic                  i_kill,
    input  logic [reg_addr_w-1:0] i_kill_addr,
    output RegWriteReq            o_head,
    output logic                  o_head_killed,
    output logic                  o_empty,
    output logic                  o_full
);
    localparam int PW = $clog2(DEPTH);

    RegWriteReq       r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_killed;
    logic [PW:0]      r_wr;
    logic [PW:0]      r_rd;
    logic [PW-1:0]    w_wi;
    logic [PW-1:0]    w_ri;

    assign w_wi          = r_wr[PW-1:0];
    assign w_ri          = r_rd[PW-1:0];
    assign o_empty       = r_wr == r_rd;
    assign o_full        = (r_wr[PW] != r_rd[PW]) && (w_wi == w_ri);
    assign o_head        = r_data[w_ri];
    assign o_head_killed = r_killed[w_ri];

    // Later assignments win: a slot freed by pop and refilled by push in one cycle ends up fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_valid  <= '0;
            r_killed <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (i_kill && r_valid[i] && r_data[i].addr == i_kill_addr) r_killed[i] <= 1'b1;
            if (i_pop && !o_empty) begin
                r_valid[w_ri]  <= 1'b0;
                r_killed[w_ri] <= 1'b0;
                r_rd           <= r_rd + 1'b1;
            end
            if (i_push && (!o_full || i_pop)) begin
                r_data[w_wi]   <= i_push_req;
                r_valid[w_wi]  <= 1'b1;
                r_killed[w_wi] <= 1'b0;
                r_wr           <= r_wr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-file write port between commit and a long-latency source.
// Define REG_WRITE_ARB_STARVE_EN to add the starvation counter and forced-drain commit bubble.
module reg_write_arbiter
    import ProcessorTypes::*;
#(
    parameter int DEPTH        = reg_write_arb_depth,
    parameter int STARVE_LIMIT = reg_write_arb_starve_limit,
    parameter int ADDR_W       = reg_addr_w,
    parameter int DATA_W       = reg_data_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commitValid,
    input  logic [ADDR_W-1:0] commitAddr,
    input  logic [DATA_W-1:0] commitValue,
    input  logic              longValid,
    output logic              longReady,
    input  logic [ADDR_W-1:0] longAddr,
    input  logic [DATA_W-1:0] longValue,
    output logic              commitStall,
    output logic              writeEnable,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] writeValue
);
    RegWriteReq w_head;
    RegWriteReq w_long_req;
    logic       w_head_killed;
    logic       w_empty;
    logic       w_full;
    logic       w_commit;
    logic       w_long_live;
    logic       w_pop;
    logic       w_bypass;
    logic       w_push;

    assign longReady  = !rst && !w_full;
    assign w_commit   = commitValid && commitAddr != '0;
    // A same-cycle commit to the same register is younger, so the long result is dropped.
    assign w_long_live = longValid && longReady && longAddr != '0
                         && !(commitValid && commitAddr == longAddr);
    assign w_pop      = !rst && !w_commit && !w_empty;
    assign w_bypass   = !w_commit && w_empty && w_long_live;
    assign w_push     = w_long_live && !w_bypass;
    assign w_long_req = '{addr: longAddr, value: longValue};

    assign writeEnable = !rst && (w_commit || (w_pop && !w_head_killed) || w_bypass);
    assign writeAddr   = w_commit ? commitAddr  : !w_empty ? w_head.addr  : longAddr;
    assign writeValue  = w_commit ? commitValue : !w_empty ? w_head.value : longValue;

    reg_write_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_req   (w_long_req),
        .i_pop        (w_pop),
        .i_kill       (commitValid),
        .i_kill_addr  (commitAddr),
        .o_head       (w_head),
        .o_head_killed(w_head_killed),
        .o_empty      (w_empty),
        .o_full       (w_full)
    );

`ifdef REG_WRITE_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] r_starve;
    logic          r_stall;
    logic          w_starved;

    // Reaching the limit this cycle schedules the bubble and restarts the count.
    assign w_starved = !w_empty && !w_pop && r_starve == CW'(STARVE_LIMIT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_stall  <= w_starved;
            r_starve <= (w_empty || w_pop || w_starved) ? '0 : r_starve + 1'b1;
        end
    end

    assign commitStall = r_stall;
`else
    logic w_unused_limit;
    assign w_unused_limit = STARVE_LIMIT != 0;
    assign commitStall    = 1'b0;
`endif

    assert property (@(posedge clk) disable iff (rst) commitStall |-> !commitValid);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and randomized checks of reg_write_arbiter against a queue-based reference model
module tb_reg_write_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;
`ifdef REG_WRITE_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commitValid = 1'b0;
    logic [4:0]  commitAddr = '0;
    logic [31:0] commitValue = '0;
    logic        longValid = 1'b0;
    logic [4:0]  longAddr = '0;
    logic [31:0] longValue = '0;
    logic        longReady;
    logic        commitStall;
    logic        writeEnable;
    logic [4:0]  writeAddr;
    logic [31:0] writeValue;

    always #5 clk = ~clk;

    reg_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .commitValid(commitValid), .commitAddr(commitAddr), .commitValue(commitValue),
        .longValid(longValid), .longReady(longReady), .longAddr(longAddr), .longValue(longValue),
        .commitStall(commitStall), .writeEnable(writeEnable), .writeAddr(writeAddr), .writeValue(writeValue)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] v;
        bit          k;
    } ent_t;

    ent_t        q[$];
    ent_t        nq[$];
    int          wait_n, n_wait, cyc, n_cmp, n_bad;
    bit          m_stall, n_stall, e_we, e_rdy;
    logic [4:0]  e_a;
    logic [31:0] e_v;

    // Reference model: pending writes as an ordered list; port goes to commit, then oldest pending, then fresh long.
    task automatic drive(input bit r, input bit cv, input logic [4:0] ca, input logic [31:0] cd,
                         input bit lv, input logic [4:0] la, input logic [31:0] ld);
        bit commit, acc, popped;
        rst = r; commitValid = cv; commitAddr = ca; commitValue = cd;
        longValid = lv; longAddr = la; longValue = ld;
        #2;
        nq = q; n_wait = wait_n; n_stall = 1'b0; popped = 1'b0;
        e_rdy = !r && q.size() < DEPTH;
        e_we = 1'b0; e_a = '0; e_v = '0;
        if (r) begin
            nq.delete();
            n_wait = 0;
        end else begin
            commit = cv && ca != 0;
            acc = lv && e_rdy && la != 0;
            if (commit) begin
                e_we = 1'b1; e_a = ca; e_v = cd;
            end else if (nq.size() > 0) begin
                e_we = !nq[0].k; e_a = nq[0].a; e_v = nq[0].v;
                void'(nq.pop_front());
                popped = 1'b1;
            end else if (acc) begin
                e_we = 1'b1; e_a = la; e_v = ld; acc = 1'b0;
            end
            if (acc && !(cv && ca == la)) nq.push_back('{a: la, v: ld, k: 1'b0});
            if (cv) foreach (nq[i]) if (nq[i].a == ca) nq[i].k = 1'b1;
            if (STARVE) begin
                if (popped || q.size() == 0) n_wait = 0;
                else begin
                    n_wait++;
                    if (n_wait == LIMIT) begin n_stall = 1'b1; n_wait = 0; end
                end
            end
        end
    endtask

    task automatic tick();
        q = nq; wait_n = n_wait; m_stall = n_stall;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h77);
            n_cmp++; if (writeEnable !== 1'b0) begin n_bad++; $display("FAIL reset_we cyc %0d got %b want 0", cyc, writeEnable); end
            n_cmp++; if (longReady !== 1'b0) begin n_bad++; $display("FAIL reset_ready cyc %0d got %b want 0", cyc, longReady); end
            n_cmp++; if (commitStall !== 1'b0) begin n_bad++; $display("FAIL reset_stall cyc %0d got %b want 0", cyc, commitStall); end
            tick();
        end
        drive(0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_cmp++; if (longReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after cyc %0d got %b want 1", cyc, longReady); end
        tick();
    endtask

    task automatic test_directed();
        logic [4:0]  ca[14], la[14];
        logic [31:0] cd[14], ld[14];
        bit          cv[14], lv[14];
        // bypass x5; commit x3 vs long x7; x9 buffered then killed by commit x9; long to x0
        cv = '{0,0,1,0,0,1,1,0,0,0,0,1,0,0};
        ca = '{0,0,3,0,0,1,9,0,0,0,0,0,0,0};
        cd = '{0,0,'hA,0,0,'h55,'h22,0,0,0,0,'h9,0,0};
        lv = '{1,0,1,0,0,1,0,0,0,1,0,1,0,0};
        la = '{5,0,7,0,0,9,0,0,0,0,0,6,0,0};
        ld = '{'h1234,0,'hB,0,0,'h11,0,0,0,'hDEAD,0,'h66,0,0};
        for (int i = 0; i < 14; i++) begin
            drive(0, cv[i], ca[i], cd[i], lv[i], la[i], ld[i]);
            n_cmp++;
            if (writeEnable !== e_we || (e_we && {writeAddr, writeValue} !== {e_a, e_v})) begin
                n_bad++;
                $display("FAIL directed_write step %0d got we=%b x%0d=%h want we=%b x%0d=%h", i, writeEnable, writeAddr, writeValue, e_we, e_a, e_v);
            end
            n_cmp++; if (longReady !== e_rdy) begin n_bad++; $display("FAIL directed_ready step %0d got %b want %b", i, longReady, e_rdy); end
            n_cmp++; if (commitStall !== m_stall) begin n_bad++; $display("FAIL directed_stall step %0d got %b want %b", i, commitStall, m_stall); end
            tick();
        end
    endtask

    task automatic test_starvation();
        int stalls = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, i < 32 && !m_stall, 5'(1 + i % 15), 32'(i), i < 32, 5'(16 + i % 16), 32'h1000 + 32'(i));
            if (commitStall === 1'b1) stalls++;
            n_cmp++;
            if (writeEnable !== e_we || (e_we && {writeAddr, writeValue} !== {e_a, e_v})) begin
                n_bad++;
                $display("FAIL starve_write cyc %0d got we=%b x%0d=%h want we=%b x%0d=%h", cyc, writeEnable, writeAddr, writeValue, e_we, e_a, e_v);
            end
            n_cmp++; if (longReady !== e_rdy) begin n_bad++; $display("FAIL starve_ready cyc %0d got %b want %b", cyc, longReady, e_rdy); end
            n_cmp++; if (commitStall !== m_stall) begin n_bad++; $display("FAIL starve_stall cyc %0d got %b want %b", cyc, commitStall, m_stall); end
            tick();
        end
        n_cmp++;
        if ((STARVE && stalls == 0) || (!STARVE && stalls != 0)) begin
            n_bad++; $display("FAIL starve_count got %0d stall cycles, feature enabled=%b", stalls, STARVE);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20); tick();
        drive(0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h21); tick();
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            n_cmp++; if (writeEnable !== 1'b0) begin n_bad++; $display("FAIL rstmid_we step %0d got %b want 0", i, writeEnable); end
            n_cmp++; if (longReady !== e_rdy) begin n_bad++; $display("FAIL rstmid_ready step %0d got %b want %b", i, longReady, e_rdy); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(99) == 0, !m_stall && $urandom_range(2) != 0, 5'($urandom_range(7)), $urandom,
                  $urandom_range(1) == 1, 5'($urandom_range(7)), $urandom);
            n_cmp++;
            if (writeEnable !== e_we || (e_we && {writeAddr, writeValue} !== {e_a, e_v})) begin
                n_bad++;
                $display("FAIL random_write cyc %0d got we=%b x%0d=%h want we=%b x%0d=%h", cyc, writeEnable, writeAddr, writeValue, e_we, e_a, e_v);
            end
            n_cmp++; if (longReady !== e_rdy) begin n_bad++; $display("FAIL random_ready cyc %0d got %b want %b", cyc, longReady, e_rdy); end
            n_cmp++; if (commitStall !== m_stall) begin n_bad++; $display("FAIL random_stall cyc %0d got %b want %b", cyc, commitStall, m_stall); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
